// File: rtl/selector_lane_scheduler.sv
`timescale 1ns/1ps
// Purpose: runs one raster frame across NUM_LANES block-selector lanes, round-robin dispatch, in-order retirement.
// Latency: the dispatch pulse appears 1 cycle after the decision; a captured result is offered on pix_* 1 cycle after lane_done_in.
// Backpressure: pix_ready_in low holds pix_* stable; dispatch stalls while the next lane's result slot is still full.
// Optional feature: define SCHED_PERF_EN to enable the frame/stall cycle counters (outputs tie to 0 otherwise).
// Ports: clk_in/rst_n_in (async active-low); start_in/curr_time_in frame start and time;
//   lane_valid/x/y_out dispatch to lanes; lane_ready/done/data_in lane status and results;
//   pix_valid/ready/x/y/data retired results; curr_time_out, busy_out, frame_done_out, err_out;
//   frame_cycles_out/stall_cycles_out performance counters.
module selector_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int H_MAX     = 1024,
  parameter int V_MAX     = 768,
  parameter int RES_W     = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       start_in,
  input  logic [17:0]                curr_time_in,
  output logic [NUM_LANES-1:0]       lane_valid_out,
  output logic [NUM_LANES*11-1:0]    lane_x_out,
  output logic [NUM_LANES*10-1:0]    lane_y_out,
  input  logic [NUM_LANES-1:0]       lane_ready_in,
  input  logic [NUM_LANES-1:0]       lane_done_in,
  input  logic [NUM_LANES*RES_W-1:0] lane_data_in,
  output logic                       pix_valid_out,
  input  logic                       pix_ready_in,
  output logic [10:0]                pix_x_out,
  output logic [9:0]                 pix_y_out,
  output logic [RES_W-1:0]           pix_data_out,
  output logic [17:0]                curr_time_out,
  output logic                       busy_out,
  output logic                       frame_done_out,
  output logic                       err_out,
  output logic [31:0]                frame_cycles_out,
  output logic [31:0]                stall_cycles_out
);

  localparam int         PW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [10:0] X_LAST = 11'(H_MAX - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_MAX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]        disp_ptr, ret_ptr;
  logic [10:0]          x_cnt;
  logic [9:0]           y_cnt;
  logic [NUM_LANES-1:0] outstanding, slot_full;
  logic [RES_W-1:0]     slot_dat [NUM_LANES];
  logic [10:0]          slot_x   [NUM_LANES];
  logic [9:0]           slot_y   [NUM_LANES];

  logic                 start_acc, disp_go, last_px, retire, last_ret, err_evt;
  logic [NUM_LANES-1:0] disp_mask, ret_mask, capture;

  assign start_acc = (state == ST_IDLE) && start_in;
  // Slot emptiness is the registered flag, so a lane retired this cycle is reused one cycle later.
  assign disp_go   = (state == ST_RUN) && lane_ready_in[disp_ptr] &&
                     !outstanding[disp_ptr] && !slot_full[disp_ptr];
  assign last_px   = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  assign pix_valid_out = slot_full[ret_ptr];
  assign pix_x_out     = slot_x[ret_ptr];
  assign pix_y_out     = slot_y[ret_ptr];
  assign pix_data_out  = slot_dat[ret_ptr];
  assign retire        = pix_valid_out && pix_ready_in;
  assign last_ret      = retire && (pix_x_out == X_LAST) && (pix_y_out == Y_LAST);

  // A done pulse is only legal from a lane that owns an in-flight pixel and whose slot is free.
  assign capture = lane_done_in & outstanding & ~slot_full;
  assign err_evt = |(lane_done_in & ~capture);

  always_comb begin
    disp_mask = '0;
    ret_mask  = '0;
    disp_mask[disp_ptr] = disp_go;
    ret_mask[ret_ptr]   = retire;
  end

  always_comb begin
    state_nxt      = state;
    busy_out       = 1'b0;
    frame_done_out = 1'b0;
    case (state)
      ST_IDLE:  if (start_in) state_nxt = ST_RUN;
      ST_RUN: begin
        busy_out = 1'b1;
        if (disp_go && last_px) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_out = 1'b1;
        if (last_ret) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        frame_done_out = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      disp_ptr       <= '0;
      ret_ptr        <= '0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      outstanding    <= '0;
      slot_full      <= '0;
      lane_valid_out <= '0;
      lane_x_out     <= '0;
      lane_y_out     <= '0;
      curr_time_out  <= '0;
      err_out        <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        slot_dat[k] <= '0;
        slot_x[k]   <= '0;
        slot_y[k]   <= '0;
      end
    end else begin
      state          <= state_nxt;
      lane_valid_out <= disp_mask;
      outstanding    <= (outstanding & ~capture) | disp_mask;
      slot_full      <= (slot_full & ~ret_mask) | capture;
      err_out        <= err_evt | (err_out & ~start_acc);
      if (start_acc) begin
        curr_time_out <= curr_time_in;
        disp_ptr      <= '0;
        ret_ptr       <= '0;
        x_cnt         <= '0;
        y_cnt         <= '0;
      end else begin
        if (disp_go) begin
          lane_x_out[disp_ptr*11 +: 11] <= x_cnt;
          lane_y_out[disp_ptr*10 +: 10] <= y_cnt;
          disp_ptr <= disp_ptr + 1'b1;
          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            // Wrap y on the final pixel so counters rest at (0,0) between frames.
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end
        if (retire) ret_ptr <= ret_ptr + 1'b1;
      end
      // The lane's x/y outputs still hold its pixel coordinates, since a lane is not re-dispatched while busy.
      for (int k = 0; k < NUM_LANES; k++) begin
        if (capture[k]) begin
          slot_dat[k] <= lane_data_in[k*RES_W +: RES_W];
          slot_x[k]   <= lane_x_out[k*11 +: 11];
          slot_y[k]   <= lane_y_out[k*10 +: 10];
        end
      end
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] frame_cyc, stall_cyc;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cyc <= '0;
      stall_cyc <= '0;
    end else if (start_acc) begin
      frame_cyc <= '0;
      stall_cyc <= '0;
    end else begin
      if (busy_out && (frame_cyc != 32'hFFFF_FFFF)) frame_cyc <= frame_cyc + 32'd1;
      if (pix_valid_out && !pix_ready_in && (stall_cyc != 32'hFFFF_FFFF)) stall_cyc <= stall_cyc + 32'd1;
    end
  end

  assign frame_cycles_out = frame_cyc;
  assign stall_cycles_out = stall_cyc;
`else
  assign frame_cycles_out = 32'd0;
  assign stall_cycles_out = 32'd0;
`endif

endmodule

// File: tb/tb_selector_lane_scheduler.sv
`timescale 1ns/1ps
// Bench for selector_lane_scheduler: 4 lanes, 4x2 frame, lanes modelled as fixed-latency units.
// Latency: not applicable (stimulus/scoreboard harness).
// Backpressure: pix_ready_in is driven by the scenario tasks.
module tb_selector_lane_scheduler;

  localparam int NL = 4, HM = 4, VM = 2, RW = 64, NPIX = HM * VM;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              start_in = 1'b0;
  logic [17:0]       curr_time_in = '0;
  logic [NL-1:0]     lane_valid_out;
  logic [NL*11-1:0]  lane_x_out;
  logic [NL*10-1:0]  lane_y_out;
  logic [NL-1:0]     lane_ready_in = '1;
  logic [NL-1:0]     lane_done_in;
  logic [NL*RW-1:0]  lane_data_in = '0;
  logic              pix_valid_out;
  logic              pix_ready_in = 1'b1;
  logic [10:0]       pix_x_out;
  logic [9:0]        pix_y_out;
  logic [RW-1:0]     pix_data_out;
  logic [17:0]       curr_time_out;
  logic              busy_out, frame_done_out, err_out;
  logic [31:0]       frame_cycles_out, stall_cycles_out;

  logic [NL-1:0] done_m = '0;
  logic [NL-1:0] inj = '0;
  assign lane_done_in = done_m | inj;

  typedef struct packed {
    logic [10:0]   x;
    logic [9:0]    y;
    logic [RW-1:0] d;
  } pix_t;

  pix_t exp_q[$];
  int checks = 0, errors = 0;
  int disp_cnt = 0, ret_cnt = 0, done_cnt = 0, frame_id = 0;
  int lat [NL] = '{14, 14, 14, 14};

  always #5 clk_in = ~clk_in;

  selector_lane_scheduler #(.NUM_LANES(NL), .H_MAX(HM), .V_MAX(VM), .RES_W(RW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .curr_time_in(curr_time_in),
    .lane_valid_out(lane_valid_out), .lane_x_out(lane_x_out), .lane_y_out(lane_y_out),
    .lane_ready_in(lane_ready_in), .lane_done_in(lane_done_in), .lane_data_in(lane_data_in),
    .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in), .pix_x_out(pix_x_out),
    .pix_y_out(pix_y_out), .pix_data_out(pix_data_out), .curr_time_out(curr_time_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out), .err_out(err_out),
    .frame_cycles_out(frame_cycles_out), .stall_cycles_out(stall_cycles_out)
  );

  function automatic logic [RW-1:0] mk_data(input int fr, input logic [10:0] x, input logic [9:0] y);
    logic [15:0] f;
    f = fr[15:0];
    return {16'hDEAD, f, 11'd0, x, y};
  endfunction

  // Each lane answers lat[k] cycles after its dispatch pulse, tagging the result with frame and pixel.
  task automatic lane_model();
    int          cnt [NL];
    logic [10:0] lx [NL];
    logic [9:0]  ly [NL];
    forever begin
      @(negedge clk_in);
      done_m = '0;
      if (!rst_n_in) begin
        for (int k = 0; k < NL; k++) cnt[k] = 0;
        lane_ready_in = '1;
      end else begin
        for (int k = 0; k < NL; k++) begin
          if (cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) begin
              done_m[k] = 1'b1;
              lane_data_in[k*RW +: RW] = mk_data(frame_id, lx[k], ly[k]);
            end
          end
          if (lane_valid_out[k]) begin
            cnt[k] = lat[k];
            lx[k]  = lane_x_out[k*11 +: 11];
            ly[k]  = lane_y_out[k*10 +: 10];
          end
          lane_ready_in[k] = (cnt[k] == 0);
        end
      end
    end
  endtask

  // Checks dispatch order/coordinates and pops the scoreboard on every output handshake.
  task automatic monitor();
    pix_t e;
    int   k;
    forever begin
      @(negedge clk_in);
      #3;
      if (rst_n_in) begin
        if (lane_valid_out != '0) begin
          k = disp_cnt % NL;
          checks++;
          if (lane_valid_out !== (NL'(1) << k)) begin
            errors++;
            $display("FAIL dispatch_lane idx=%0d got=%b want=%b", disp_cnt, lane_valid_out, NL'(1) << k);
          end
          checks++;
          if (lane_x_out[k*11 +: 11] !== 11'(disp_cnt % HM) || lane_y_out[k*10 +: 10] !== 10'(disp_cnt / HM)) begin
            errors++;
            $display("FAIL dispatch_xy idx=%0d got=(%0d,%0d) want=(%0d,%0d)", disp_cnt,
                     lane_x_out[k*11 +: 11], lane_y_out[k*10 +: 10], disp_cnt % HM, disp_cnt / HM);
          end
          disp_cnt++;
        end
        if (pix_valid_out && pix_ready_in) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL retire_extra got=(%0d,%0d) want=none", pix_x_out, pix_y_out);
          end else begin
            e = exp_q.pop_front();
            if ({pix_x_out, pix_y_out, pix_data_out} !== e) begin
              errors++;
              $display("FAIL retire_pix got=(%0d,%0d,%h) want=(%0d,%0d,%h)",
                       pix_x_out, pix_y_out, pix_data_out, e.x, e.y, e.d);
            end
          end
          ret_cnt++;
        end
        if (frame_done_out) done_cnt++;
      end
    end
  endtask

  task automatic run_frame(input logic [17:0] t, input int fr);
    pix_t e;
    frame_id = fr;
    disp_cnt = 0;
    ret_cnt  = 0;
    done_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      e.x = 11'(i % HM);
      e.y = 10'(i / HM);
      e.d = mk_data(fr, e.x, e.y);
      exp_q.push_back(e);
    end
    @(negedge clk_in); #1;
    curr_time_in = t;
    start_in = 1'b1;
    @(negedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_frame(input logic [17:0] t);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk_in); #4;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL frame_timeout got=no_done want=frame_done within 3000 cycles");
    end
    repeat (3) @(negedge clk_in);
    #1;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL frame_done_count got=%0d want=1", done_cnt); end
    checks++;
    if (ret_cnt != NPIX || exp_q.size() != 0) begin
      errors++;
      $display("FAIL retire_count got=%0d left=%0d want=%0d left=0", ret_cnt, exp_q.size(), NPIX);
    end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL busy_after_frame got=%b want=0", busy_out); end
    checks++;
    if (curr_time_out !== t) begin errors++; $display("FAIL curr_time got=%h want=%h", curr_time_out, t); end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    #1;
    checks++;
    if (lane_valid_out !== '0 || disp_cnt != 0) begin
      errors++; $display("FAIL reset_lane_valid got=%b/%0d want=0/0", lane_valid_out, disp_cnt);
    end
    checks++;
    if (lane_x_out !== '0 || lane_y_out !== '0) begin
      errors++; $display("FAIL reset_lane_xy got=%h/%h want=0/0", lane_x_out, lane_y_out);
    end
    checks++;
    if ({pix_valid_out, pix_x_out, pix_y_out, pix_data_out} !== '0) begin
      errors++; $display("FAIL reset_pix got=%b,%0d,%0d,%h want=0", pix_valid_out, pix_x_out, pix_y_out, pix_data_out);
    end
    checks++;
    if ({busy_out, frame_done_out, err_out} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b%b%b want=000", busy_out, frame_done_out, err_out);
    end
    checks++;
    if (curr_time_out !== '0 || frame_cycles_out !== '0 || stall_cycles_out !== '0) begin
      errors++; $display("FAIL reset_counters got=%h/%h/%h want=0", curr_time_out, frame_cycles_out, stall_cycles_out);
    end
  endtask

  task automatic test_basic_frame();
    run_frame(18'h1_2345, 1);
    checks++;
    if (busy_out !== 1'b1) begin errors++; $display("FAIL busy_in_run got=%b want=1", busy_out); end
    // A start during the frame must not relatch the time.
    repeat (3) @(negedge clk_in);
    #1 curr_time_in = 18'h3_FFFF;
    start_in = 1'b1;
    @(negedge clk_in); #1 start_in = 1'b0;
    wait_frame(18'h1_2345);
    checks++;
    if (err_out !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", err_out); end
`ifdef SCHED_PERF_EN
    checks++;
    if (frame_cycles_out == 32'd0 || stall_cycles_out !== 32'd0) begin
      errors++; $display("FAIL basic_perf got=%0d/%0d want=nonzero/0", frame_cycles_out, stall_cycles_out);
    end
`endif
  endtask

  task automatic test_slow_lane();
    lat[2] = 30;
    run_frame(18'h0_0A5A, 2);
    wait_frame(18'h0_0A5A);
    lat[2] = 14;
  endtask

  task automatic test_backpressure();
    int   n = 0, unstable = 0;
    pix_t snap;
    run_frame(18'h2_0001, 3);
    while (!pix_valid_out && n < 200) begin
      @(negedge clk_in); #1;
      n++;
    end
    checks++;
    if (!pix_valid_out) begin errors++; $display("FAIL bp_first_valid got=0 want=1"); end
    pix_ready_in = 1'b0;
    snap = {pix_x_out, pix_y_out, pix_data_out};
    repeat (50) begin
      @(negedge clk_in); #1;
      if (!pix_valid_out || {pix_x_out, pix_y_out, pix_data_out} !== snap) unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_hold got=%0d changed cycles want=0", unstable); end
    checks++;
    if (disp_cnt != NL) begin errors++; $display("FAIL bp_dispatch_stall got=%0d dispatches want=%0d", disp_cnt, NL); end
    pix_ready_in = 1'b1;
    wait_frame(18'h2_0001);
    checks++;
`ifdef SCHED_PERF_EN
    if (stall_cycles_out !== 32'd50) begin errors++; $display("FAIL bp_stall_count got=%0d want=50", stall_cycles_out); end
`else
    if (stall_cycles_out !== 32'd0) begin errors++; $display("FAIL bp_stall_count got=%0d want=0", stall_cycles_out); end
`endif
  endtask

  task automatic test_spurious_done();
    int n = 0;
    run_frame(18'h0_7777, 4);
    while (!(busy_out && !lane_valid_out[1] && lane_ready_in[1] && !done_m[1]) && n < 20) begin
      @(negedge clk_in); #1;
      n++;
    end
    checks++;
    if (err_out !== 1'b0) begin errors++; $display("FAIL err_before got=%b want=0", err_out); end
    inj[1] = 1'b1;
    @(negedge clk_in); #1 inj[1] = 1'b0;
    checks++;
    if (err_out !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", err_out); end
    wait_frame(18'h0_7777);
    checks++;
    if (err_out !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err_out); end
    run_frame(18'h0_1111, 5);
    checks++;
    if (err_out !== 1'b0) begin errors++; $display("FAIL err_clear_on_start got=%b want=0", err_out); end
    wait_frame(18'h0_1111);
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    run_frame(18'h1_5555, 6);
    while (!(disp_cnt == NPIX && busy_out) && n < 200) begin
      @(negedge clk_in); #1;
      n++;
    end
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({busy_out, pix_valid_out, lane_valid_out, err_out} !== '0 || lane_x_out !== '0 || curr_time_out !== '0) begin
      errors++;
      $display("FAIL async_reset got=busy%b pv%b lv%b err%b lx%h t%h want=all 0",
               busy_out, pix_valid_out, lane_valid_out, err_out, lane_x_out, curr_time_out);
    end
    @(negedge clk_in); #1 rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    run_frame(18'h0_2468, 7);
    wait_frame(18'h0_2468);
  endtask

  initial begin
    fork
      lane_model();
      monitor();
    join_none
    test_reset();
    test_basic_frame();
    test_slow_lane();
    test_backpressure();
    test_spurious_done();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
